// File: rtl/tape_pulse_decoder.sv
// tape_pulse_decoder: recovers bytes from a ZX Spectrum style tape signal.
// Half-pulse widths are measured in clk cycles, pilot/sync are qualified,
// and data half-pulses are paired into bits that assemble MSB-first.
module tape_pulse_decoder #(
  parameter int unsigned CLK_FREQ    = 27000000,
  parameter int unsigned PILOT_COUNT = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mic_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        block_start,
  output logic        block_end,
  output logic        checksum_ok,
  output logic [15:0] byte_count,
  output logic        error,
  output logic        overrun
);
  localparam int unsigned KHZ = CLK_FREQ / 1000;

  // Convert a duration in 3.5 MHz T-states into clk cycles.
  function automatic logic [17:0] tstates(input int unsigned t);
    return 18'(t * KHZ / 3500);
  endfunction

  function automatic logic [17:0] sat_inc18(input logic [17:0] v);
    return (&v) ? v : v + 18'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  localparam logic [17:0] GLITCH    = tstates(300);
  localparam logic [17:0] SYNC_MAX  = tstates(1100);
  localparam logic [17:0] PILOT_MIN = tstates(1800);
  localparam logic [17:0] PILOT_MAX = tstates(2600);
  localparam logic [17:0] BIT_SPLIT = tstates(2400);
  localparam logic [17:0] PAIR_MAX  = tstates(4500);
  localparam logic [17:0] TIMEOUT   = tstates(10000);
  localparam logic [18:0] GLITCH_X2 = {GLITCH, 1'b0};
  localparam logic [15:0] PILOT_TGT = 16'(PILOT_COUNT);

  typedef enum logic [1:0] {IDLE, PILOT, SYNC2, DATA} state_t;

  state_t      state, state_next;
  logic        mic_p0, mic_p1, mic_p2;
  logic        mic_edge;
  logic [17:0] width_cnt;
  logic [15:0] pilot_cnt;
  logic [17:0] half_w;
  logic        half_pending;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [7:0]  xor_acc;
  logic [18:0] pair_sum;
  logic        in_pilot, in_sync, timeout, pair_bad, bit_val;
  logic        pilot_first, pilot_step, start_evt, half_evt, bit_evt;
  logic        err_evt, end_evt, byte_done;
  logic [7:0]  new_byte;

  assign mic_edge = mic_p1 ^ mic_p2;
  assign in_pilot = (width_cnt >= PILOT_MIN) && (width_cnt <= PILOT_MAX);
  assign in_sync  = (width_cnt >= GLITCH) && (width_cnt < SYNC_MAX);
  assign timeout  = (width_cnt == TIMEOUT);
  assign pair_sum = {1'b0, half_w} + {1'b0, width_cnt};
  assign pair_bad = (pair_sum < GLITCH_X2) || (pair_sum > {1'b0, PAIR_MAX});
  assign bit_val  = (pair_sum >= {1'b0, BIT_SPLIT});
  assign new_byte = {shift_reg[6:0], bit_val};

  // Input synchronizer (p0/p1) plus previous level (p2) and width counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mic_p0    <= 1'b0;
      mic_p1    <= 1'b0;
      mic_p2    <= 1'b0;
      width_cnt <= '0;
    end else begin
      mic_p0    <= mic_in;
      mic_p1    <= mic_p0;
      mic_p2    <= mic_p1;
      width_cnt <= mic_edge ? 18'd0 : sat_inc18(width_cnt);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode from the measured half-pulse width
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (mic_edge && in_pilot) state_next = PILOT;
        PILOT: begin
          if (mic_edge) begin
            if (in_pilot)                              state_next = PILOT;
            else if (in_sync && pilot_cnt >= PILOT_TGT) state_next = SYNC2;
            else                                       state_next = IDLE;
          end else if (timeout) begin
            state_next = IDLE;
          end
        end
        SYNC2: begin
          if (mic_edge)     state_next = in_sync ? DATA : IDLE;
          else if (timeout) state_next = IDLE;
        end
        DATA: begin
          if (mic_edge && half_pending && pair_bad) state_next = IDLE;
          else if (!mic_edge && timeout)            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Event strobes; all suppressed while the decoder is disabled
  always_comb begin
    pilot_first = enable && (state == IDLE)  && mic_edge && in_pilot;
    pilot_step  = enable && (state == PILOT) && mic_edge && in_pilot;
    start_evt   = enable && (state == SYNC2) && mic_edge && in_sync;
    half_evt    = enable && (state == DATA)  && mic_edge && !half_pending;
    bit_evt     = enable && (state == DATA)  && mic_edge && half_pending && !pair_bad;
    err_evt     = enable && (state == DATA)  && mic_edge && half_pending && pair_bad;
    end_evt     = enable && (state == DATA)  && !mic_edge && timeout;
    byte_done   = bit_evt && (bit_cnt == 3'd7);
  end

  // Pilot counting, bit/byte assembly and block bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pilot_cnt    <= '0;
      half_w       <= '0;
      half_pending <= 1'b0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      xor_acc      <= '0;
      byte_count   <= '0;
      checksum_ok  <= 1'b0;
      overrun      <= 1'b0;
      block_start  <= 1'b0;
      block_end    <= 1'b0;
      error        <= 1'b0;
    end else begin
      block_start <= start_evt;
      block_end   <= end_evt;
      error       <= err_evt;
      if (pilot_first)                          pilot_cnt <= 16'd1;
      else if (pilot_step && pilot_cnt < PILOT_TGT) pilot_cnt <= pilot_cnt + 16'd1;
      if (start_evt) begin
        half_pending <= 1'b0;
        bit_cnt      <= '0;
        shift_reg    <= '0;
        xor_acc      <= '0;
        byte_count   <= '0;
        checksum_ok  <= 1'b0;
        overrun      <= 1'b0;
      end else begin
        if (half_evt) begin
          half_w       <= width_cnt;
          half_pending <= 1'b1;
        end
        if (bit_evt) begin
          half_pending <= 1'b0;
          shift_reg    <= new_byte;
          bit_cnt      <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          xor_acc    <= xor_acc ^ new_byte;
          byte_count <= sat_inc16(byte_count);
          if (byte_valid && !byte_ready) overrun <= 1'b1;
        end
        if (end_evt)
          checksum_ok <= (xor_acc == 8'h00) && (byte_count != 16'd0) &&
                         (bit_cnt == 3'd0) && !half_pending;
      end
    end
  end

  // Output byte holding register with valid/ready handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else if (byte_done && (!byte_valid || byte_ready)) begin
      byte_data  <= new_byte;
      byte_valid <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      byte_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tape_pulse_decoder.sv
// Testbench for tape_pulse_decoder, run at CLK_FREQ=70000 so one clk equals
// 50 T-states: pilot 43 clk, sync 13/14 clk, bit0 17+17, bit1 34+34,
// timeout 200 clk. Bytes and checksums are scoreboarded.
module tb_tape_pulse_decoder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        mic_in = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        block_start, block_end, checksum_ok, error, overrun;
  logic [15:0] byte_count;

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_end = 0, n_err = 0;
  int s0, e0, r0;
  logic [7:0] exp_q[$];
  logic       csum_q[$];
  logic [7:0] exp_b;
  logic       exp_c;

  always #5 clk = ~clk;

  tape_pulse_decoder #(.CLK_FREQ(70000), .PILOT_COUNT(32)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mic_in(mic_in),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .block_start(block_start), .block_end(block_end),
    .checksum_ok(checksum_ok), .byte_count(byte_count),
    .error(error), .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: pops expected bytes on handshake and checksums on block_end
  always @(negedge clk) begin
    if (reset_n) begin
      if (block_start) n_start++;
      if (error) n_err++;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL byte_unexpected: got 0x%02h expected none", byte_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte_data", int'(byte_data), int'(exp_b));
        end
      end
      if (block_end) begin
        n_end++;
        if (csum_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL block_end_unexpected: got pulse expected none");
        end else begin
          exp_c = csum_q.pop_front();
          check("checksum_ok", int'(checksum_ok), int'(exp_c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic half(input int n);
    mic_in = ~mic_in;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    half(b ? 34 : 17);
    half(b ? 34 : 17);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic lead(input int pilots);
    repeat (100) tick();
    for (int i = 0; i < pilots; i++) half(43);
    half(13);
    half(14);
  endtask

  task automatic tail();
    half(240);
    repeat (20) tick();
  endtask

  task automatic mark();
    s0 = n_start; e0 = n_end; r0 = n_err;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_byte_data", int'(byte_data), 0);
    check("rst_block_start", int'(block_start), 0);
    check("rst_block_end", int'(block_end), 0);
    check("rst_checksum_ok", int'(checksum_ok), 0);
    check("rst_byte_count", int'(byte_count), 0);
    check("rst_error", int'(error), 0);
    check("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Good block FF,AA,55 -> XOR 0
    mark();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    csum_q.push_back(1'b1);
    lead(40); send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h55); tail();
    check("t1_block_start", n_start - s0, 1);
    check("t1_block_end", n_end - e0, 1);
    check("t1_error", n_err - r0, 0);
    check("t1_byte_count", int'(byte_count), 3);
    check("t1_checksum_ok", int'(checksum_ok), 1);
    check("t1_overrun", int'(overrun), 0);

    // Bad checksum: last byte 54 -> XOR 01
    mark();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hAA); exp_q.push_back(8'h54);
    csum_q.push_back(1'b0);
    lead(40); send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h54); tail();
    check("t2_block_end", n_end - e0, 1);
    check("t2_checksum_ok", int'(checksum_ok), 0);
    check("t2_byte_count", int'(byte_count), 3);

    // Too few pilot pulses: nothing decoded, counters untouched
    mark();
    lead(10); send_byte(8'h81); tail();
    check("t3_block_start", n_start - s0, 0);
    check("t3_block_end", n_end - e0, 0);
    check("t3_error", n_err - r0, 0);
    check("t3_byte_count", int'(byte_count), 3);

    // Consumer stalled for two bytes: first held, second dropped
    mark();
    byte_ready = 1'b0;
    exp_q.push_back(8'h12);
    csum_q.push_back(1'b0);
    lead(40); send_byte(8'h12); send_byte(8'h34); tail();
    check("t4_block_end", n_end - e0, 1);
    check("t4_overrun", int'(overrun), 1);
    check("t4_byte_count", int'(byte_count), 2);
    check("t4_byte_valid_held", int'(byte_valid), 1);
    check("t4_byte_data_held", int'(byte_data), 'h12);
    byte_ready = 1'b1;
    repeat (3) tick();
    check("t4_byte_valid_clear", int'(byte_valid), 0);

    // Over-long bit pair: framing error, no block_end
    mark();
    exp_q.push_back(8'hA5);
    lead(40); send_byte(8'hA5); half(60); half(60); tail();
    check("t5_error", n_err - r0, 1);
    check("t5_block_end", n_end - e0, 0);
    check("t5_byte_count", int'(byte_count), 1);

    // Enable dropped mid-block: no block_end or error
    mark();
    exp_q.push_back(8'h3C);
    lead(40); send_byte(8'h3C); send_bit(1'b1);
    enable = 1'b0;
    repeat (10) tick();
    enable = 1'b1;
    tail();
    check("t7_block_end", n_end - e0, 0);
    check("t7_error", n_err - r0, 0);
    check("t7_byte_count", int'(byte_count), 1);

    // Reset mid-byte, then a fresh good block
    lead(40); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_rst_byte_count", int'(byte_count), 0);
    check("t6_rst_overrun", int'(overrun), 0);
    mark();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    csum_q.push_back(1'b1);
    lead(40); send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h55); tail();
    check("t6_block_start", n_start - s0, 1);
    check("t6_block_end", n_end - e0, 1);
    check("t6_error", n_err - r0, 0);
    check("t6_byte_count", int'(byte_count), 3);
    check("t6_overrun", int'(overrun), 0);

    repeat (10) tick();
    check("bytes_outstanding", exp_q.size(), 0);
    check("checksums_outstanding", csum_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
